mem_bus_ctrl: RTL and testbench

//  Bus master for the CPU memory space. Takes a single-outstanding CPU read/write request
//  and decodes it to the program ROM or the work/video RAM. Drives their addr/enable/oenable

---
 rtl/mem_bus_ctrl_if.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 89 ++++++++
 tb/tb_mem_bus_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: CPU request/response and memory control signals of the memory bus controller
interface mem_bus_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_fault;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  rom_enable;
    logic                  ram_enable;
    logic                  bus_oenable;
    logic                  bus_wenable;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_fault,
        output bus_addr, rom_enable, ram_enable, bus_oenable, bus_wenable
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_fault,
        input  bus_addr, rom_enable, ram_enable, bus_oenable, bus_wenable
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: decodes single-outstanding CPU accesses onto ROM/RAM with fixed wait states
module mem_bus_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_SIZE    = 8192,
    parameter int RAM_BASE    = 'h2000,
    parameter int RAM_SIZE    = 8192,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_ctrl_if.master        mb,
    inout  wire  [DATA_WIDTH-1:0] bus_data
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic [32:0] ROM_END = 33'(ROM_SIZE);
    localparam logic [32:0] RAM_LO  = 33'(RAM_BASE);
    localparam logic [32:0] RAM_HI  = 33'(RAM_BASE) + 33'(RAM_SIZE);
    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  we_q;
    logic                  fault_q;
    logic                  drv;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [32:0]           addr_x;
    logic                  rom_hit;
    logic                  ram_hit;
    // bounds compared one bit wider than any address so the RAM end cannot wrap
    assign addr_x  = 33'(mb.cpu_addr);
    assign rom_hit = addr_x < ROM_END;
    assign ram_hit = addr_x >= RAM_LO && addr_x < RAM_HI;
    assign bus_data = drv ? wdata_q : 'z;
    // request acceptance, wait-state countdown and registered bus/CPU outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            fault_q        <= 1'b0;
            drv            <= 1'b0;
            wdata_q        <= '0;
            mb.cpu_ready   <= 1'b0;
            mb.cpu_fault   <= 1'b0;
            mb.cpu_rdata   <= '0;
            mb.bus_addr    <= '0;
            mb.rom_enable  <= 1'b0;
            mb.ram_enable  <= 1'b0;
            mb.bus_oenable <= 1'b0;
            mb.bus_wenable <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mb.cpu_req) begin
                    state          <= ACCESS;
                    cnt            <= 4'(WAIT_STATES);
                    we_q           <= mb.cpu_we;
                    wdata_q        <= mb.cpu_wdata;
                    fault_q        <= !(rom_hit && !mb.cpu_we) && !ram_hit;
                    drv            <= mb.cpu_we && ram_hit;
                    mb.bus_addr    <= ram_hit ? mb.cpu_addr - ADDR_WIDTH'(RAM_BASE) : rom_hit ? mb.cpu_addr : '0;
                    mb.rom_enable  <= rom_hit && !mb.cpu_we;
                    mb.ram_enable  <= ram_hit;
                    mb.bus_oenable <= !mb.cpu_we && (rom_hit || ram_hit);
                    mb.bus_wenable <= mb.cpu_we && ram_hit;
                end
                ACCESS: if (cnt == '0) begin
                    state          <= DONE;
                    drv            <= 1'b0;
                    mb.rom_enable  <= 1'b0;
                    mb.ram_enable  <= 1'b0;
                    mb.bus_oenable <= 1'b0;
                    mb.bus_wenable <= 1'b0;
                    mb.cpu_ready   <= 1'b1;
                    mb.cpu_fault   <= fault_q;
                    if (!we_q) mb.cpu_rdata <= fault_q ? '1 : bus_data;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                DONE: begin
                    state        <= IDLE;
                    mb.cpu_ready <= 1'b0;
                    mb.cpu_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed checks of decode, timing, faults, reset abort and back-to-back cadence
module tb_mem_bus_ctrl;
    logic clk;
    logic rst;
    int tests;
    int fails;
    wire [7:0] bus_data;
    wire [7:0] bus_data2;
    logic [7:0] ram [0:8191];
    mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b ();
    mem_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) b2 ();
    mem_bus_ctrl #(.WAIT_STATES(1)) dut (.clk(clk), .rst(rst), .mb(b), .bus_data(bus_data));
    mem_bus_ctrl #(.WAIT_STATES(0)) dut2 (.clk(clk), .rst(rst), .mb(b2), .bus_data(bus_data2));

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        return a == 16'h0005 ? 8'h3E : a[7:0] ^ 8'h5A;
    endfunction

    assign bus_data  = b.bus_oenable ? (b.rom_enable ? rom_f(b.bus_addr) : ram[b.bus_addr[12:0]]) : 'z;
    assign bus_data2 = b2.bus_oenable ? rom_f(b2.bus_addr) : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model stores the bus value on every write-enabled edge
    always @(posedge clk) if (b.ram_enable && b.bus_wenable) ram[b.bus_addr[12:0]] <= bus_data;

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // one W=1 transfer starting at a falling edge (cycle 0), checked cycle by cycle
    task automatic xfer(input logic we, input logic [15:0] a, input logic [7:0] wd,
                        input logic er, input logic em, input logic [15:0] ea,
                        input logic [7:0] erd, input logic ef);
        b.cpu_req   = 1'b1;
        b.cpu_we    = we;
        b.cpu_addr  = a;
        b.cpu_wdata = wd;
        @(negedge clk);
        for (int c = 1; c <= 2; c++) begin
            chk("rom_en", 16'(b.rom_enable), 16'(er));
            chk("ram_en", 16'(b.ram_enable), 16'(em));
            chk("oe", 16'(b.bus_oenable), 16'(!we && (er || em)));
            chk("we", 16'(b.bus_wenable), 16'(we && em));
            chk("drive", 16'(dut.drv), 16'(we && em));
            chk("rdy_low", 16'(b.cpu_ready), 16'd0);
            if (we && em) chk("wdata", 16'(bus_data), 16'(wd));
            if (er || em) chk("baddr", b.bus_addr, ea);
            @(negedge clk);
        end
        chk("rdy", 16'(b.cpu_ready), 16'd1);
        chk("fault", 16'(b.cpu_fault), 16'(ef));
        chk("rdata", 16'(b.cpu_rdata), 16'(erd));
        chk("en_off", {13'd0, b.rom_enable, b.ram_enable, b.bus_oenable | b.bus_wenable}, 16'd0);
        chk("drive_off", 16'(dut.drv), 16'd0);
        b.cpu_req = 1'b0;
        @(negedge clk);
        chk("rdy_pulse", 16'(b.cpu_ready), 16'd0);
        chk("fault_clr", 16'(b.cpu_fault), 16'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        b.cpu_req = 1'b0;
        b.cpu_we = 1'b0;
        b.cpu_addr = '0;
        b.cpu_wdata = '0;
        b2.cpu_req = 1'b0;
        b2.cpu_we = 1'b0;
        b2.cpu_addr = '0;
        b2.cpu_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 16'(b.cpu_ready), 16'd0);
        chk("rst_fault", 16'(b.cpu_fault), 16'd0);
        chk("rst_rdata", 16'(b.cpu_rdata), 16'd0);
        chk("rst_baddr", b.bus_addr, 16'd0);
        chk("rst_en", {12'd0, b.rom_enable, b.ram_enable, b.bus_oenable, b.bus_wenable}, 16'd0);
        chk("rst_drive", 16'(dut.drv), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b0, 16'h0005, 8'h00, 1'b1, 1'b0, 16'h0005, 8'h3E, 1'b0);
        xfer(1'b1, 16'h2400, 8'hA5, 1'b0, 1'b1, 16'h0400, 8'h3E, 1'b0);
        xfer(1'b0, 16'h2400, 8'h00, 1'b0, 1'b1, 16'h0400, 8'hA5, 1'b0);
        xfer(1'b1, 16'h0010, 8'h77, 1'b0, 1'b0, 16'h0000, 8'hA5, 1'b1);
        xfer(1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h4A, 1'b0);
        xfer(1'b0, 16'hF000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hFF, 1'b1);
        xfer(1'b0, 16'h4000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'hFF, 1'b1);
        xfer(1'b0, 16'h3FFF, 8'h00, 1'b0, 1'b1, 16'h1FFF, ram[13'h1FFF], 1'b0);
        b.cpu_req = 1'b1;
        b.cpu_we = 1'b1;
        b.cpu_addr = 16'h2100;
        b.cpu_wdata = 8'h5C;
        @(negedge clk);
        chk("abort_ram_en", 16'(b.ram_enable), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        b.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_en", {12'd0, b.rom_enable, b.ram_enable, b.bus_oenable, b.bus_wenable}, 16'd0);
        chk("abort_drive", 16'(dut.drv), 16'd0);
        chk("abort_ready", 16'(b.cpu_ready), 16'd0);
        @(negedge clk);
        chk("abort_no_ready", 16'(b.cpu_ready), 16'd0);
        xfer(1'b0, 16'h2400, 8'h00, 1'b0, 1'b1, 16'h0400, 8'hA5, 1'b0);
        b2.cpu_req = 1'b1;
        b2.cpu_addr = 16'h0005;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", c), 16'(b2.cpu_ready), 16'(c % 3 == 2));
            chk($sformatf("b2b_rom_en_c%0d", c), 16'(b2.rom_enable), 16'(c % 3 == 1));
        end
        chk("b2b_rdata", 16'(b2.cpu_rdata), 16'h003E);
        b2.cpu_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
